instruction_decoder: RTL and testbench
======================================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have no parameters; widths fixed.
REQ-002 clk  in  1  sole clock; all state on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 instr  in  32  instruction word: [31:29] type, [28:23] funct6, [22:18] rs1, [17:13] rs2, [17:6] imm12 (I/LOAD), [11:0] imm12 (BR/JUMP), [9:6] accel code, [5:0] rd.
REQ-005 src1_addr, src2_addr  out  8 each  register read addresses, {3'b0, 5-bit field}.
REQ-006 immediate  out  12  decoded immediate.
REQ-007 rd_addr  out  8  write address {rd_group[1:0]=2'b00, instr[5:0]}.
REQ-008 alu_funct, br_funct  out  3 each  ALU op and branch condition.
REQ-009 pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en  out  1 each  control strobes: PC redirect, jump, src2-is-immediate, writeback-from-data-mem, writeback enable.
REQ-010 decode_layer, compute_grid, decode_layer_info, compute_ifmap, send_layer_info, load_weights, load_bias, send_systolic_data, set_ifmap_o, send_optimal_move  out  1 each  accelerator command strobes, codes 0..9 in that order.

Function
REQ-011 All outputs SHALL be registered: decode of instr sampled at edge N appears after edge N, latency 1 cycle.
REQ-012 Type 000 (ALU-I): src1=rs1, src2_addr=0, immediate=instr[17:6], rd_addr from [5:0], alu_funct=funct6[5:3], src2_sel=1, wrd_en=1, wrd_sel=0.
REQ-013 Type 001 (ALU-R): src1=rs1, src2=rs2, immediate=0, rd_addr from [5:0], alu_funct=funct6[5:3], src2_sel=0, wrd_en=1, wrd_sel=0.
REQ-014 ALU codes: 000 MUL, 001 SUB, 010 AND, 011 SLL, 100 ADD, 101 SRL, 110 OR, 111 XOR (decoder passes code only).
REQ-015 Type 010 (LOAD): as ALU-I but alu_funct=100 (ADD address), wrd_sel=1.
REQ-016 Type 011 (BRANCH): src1=rs1, src2=rs2, immediate=instr[11:0], br_funct=funct6[5:3] (000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU, 110/111 never), pc_sel=1, src2_sel=0, wrd_en=0.
REQ-017 Type 111, funct6=000_111 (JUMP): immediate=instr[11:0], pc_sel=1, jump_sel=1, wrd_en=0, src addresses 0.
REQ-018 Type 111, funct6=111_111 (ACCEL): exactly one strobe asserted for code instr[9:6] in 0..9; codes 10..15 assert none; wrd_en=pc_sel=0.
REQ-019 Fields not used by a type SHALL output 0; alu_funct/br_funct 0 when unused.
REQ-020 Any other type/funct6 combination (incl. instr=0 decoded as ALU-I ADD? no: 000 with funct6[5:3]=000 is MUL of r0) SHALL decode per its type; types 100/101/110 and unlisted 111 functs are NOP: all outputs 0.
REQ-021 At most one accelerator strobe high in any cycle; strobes never high with wrd_en or pc_sel.

Reset
REQ-022 While rst=1 at an edge, every output SHALL be 0 after that edge; first decode appears one cycle after rst deasserts; reset mid-stream drops the in-flight decode.

Structure
REQ-023 Shared package: type codes, ALU codes, branch codes, accel command codes, register-address constants (ZERO 0x00 ... LAYER_CURRENT_NUM 0x08, LAYER_INFO 0x0B, WEIGHT_HEIGHT 0x0C, WEIGHT_WIDTH 0x0D, WEIGHT_LENGTH 0x15, DNN_OUT 0x17).
REQ-024 One combinational sub-module instr_decode_comb producing next-state outputs; top holds the output register only.

Verification
REQ-025 R-type {001,000000,0x0C,0x0D,0,0x15} -> src1=0x0C, src2=0x0D, rd=0x15, alu_funct=000, wrd_en=1, src2_sel=0, next cycle.
REQ-026 I-type {000,100000,0x00,imm=1,rd=0x08} -> immediate=0x001, alu_funct=100, rd=0x08, src2_sel=1; {000,110000,0,0x0AB,0x0B} -> immediate=0x0AB, alu_funct=110, rd=0x0B.
REQ-027 Branch {011,001000,0x08,0x07,0,11} -> br_funct=001, imm=11, pc_sel=1, jump_sel=0, wrd_en=0.
REQ-028 Jump {111,000111,0,201} -> immediate=201, pc_sel=1, jump_sel=1.
REQ-029 ACCEL codes 6,7,8,2 -> only load_bias, send_systolic_data, set_ifmap_o, decode_layer_info respectively, one cycle later; code 12 -> none.
REQ-030 rst=1 for one cycle mid-stream -> all outputs 0 after that edge, resume next cycle.

Source files
------------

// File: rtl/instruction_decoder_pkg.sv
// Shared definitions for the instruction decoder.
// Contents: instruction type codes, ALU and branch condition codes,
// accelerator command codes, architectural register-address constants,
// and the packed struct that carries one complete decode result.
package instruction_decoder_pkg;

    // Instruction type field instr[31:29]
    localparam logic [2:0] TYPE_ALU_I  = 3'b000;
    localparam logic [2:0] TYPE_ALU_R  = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_BRANCH = 3'b011;
    localparam logic [2:0] TYPE_SYS    = 3'b111;

    // funct6 values selecting the two defined TYPE_SYS operations
    localparam logic [5:0] FUNCT6_JUMP  = 6'b000_111;
    localparam logic [5:0] FUNCT6_ACCEL = 6'b111_111;

    // ALU operation codes (the decoder only forwards these)
    localparam logic [2:0] ALU_MUL = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // Branch condition codes; 110/111 never take the branch
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b010;
    localparam logic [2:0] BR_BGE  = 3'b011;
    localparam logic [2:0] BR_BLTU = 3'b100;
    localparam logic [2:0] BR_BGEU = 3'b101;

    // Accelerator command codes, instr[9:6]
    localparam logic [3:0] ACC_DECODE_LAYER       = 4'd0;
    localparam logic [3:0] ACC_COMPUTE_GRID       = 4'd1;
    localparam logic [3:0] ACC_DECODE_LAYER_INFO  = 4'd2;
    localparam logic [3:0] ACC_COMPUTE_IFMAP      = 4'd3;
    localparam logic [3:0] ACC_SEND_LAYER_INFO    = 4'd4;
    localparam logic [3:0] ACC_LOAD_WEIGHTS       = 4'd5;
    localparam logic [3:0] ACC_LOAD_BIAS          = 4'd6;
    localparam logic [3:0] ACC_SEND_SYSTOLIC_DATA = 4'd7;
    localparam logic [3:0] ACC_SET_IFMAP_O        = 4'd8;
    localparam logic [3:0] ACC_SEND_OPTIMAL_MOVE  = 4'd9;
    localparam int         ACC_NUM_CMDS           = 10;

    // Architectural register addresses
    localparam logic [7:0] REG_ZERO              = 8'h00;
    localparam logic [7:0] REG_LAYER_CURRENT_NUM = 8'h08;
    localparam logic [7:0] REG_LAYER_INFO        = 8'h0B;
    localparam logic [7:0] REG_WEIGHT_HEIGHT     = 8'h0C;
    localparam logic [7:0] REG_WEIGHT_WIDTH      = 8'h0D;
    localparam logic [7:0] REG_WEIGHT_LENGTH     = 8'h15;
    localparam logic [7:0] REG_DNN_OUT           = 8'h17;

    // One complete decode result; accel bit i is command code i.
    typedef struct packed {
        logic [7:0]  src1_addr;
        logic [7:0]  src2_addr;
        logic [11:0] immediate;
        logic [7:0]  rd_addr;
        logic [2:0]  alu_funct;
        logic [2:0]  br_funct;
        logic        pc_sel;
        logic        jump_sel;
        logic        src2_sel;
        logic        wrd_sel;
        logic        wrd_en;
        logic [ACC_NUM_CMDS-1:0] accel;
    } decode_t;

endpackage

// File: rtl/instruction_decoder_comb.sv
// Combinational decode of one 32-bit instruction word into a decode_t.
// Ports:
//   instr  - instruction word
//   dec    - decode result (to be registered by the parent)
// Every field not used by the decoded type is left at zero; unknown
// types and unlisted TYPE_SYS functions produce an all-zero NOP.
module instr_decode_comb
    import instruction_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [2:0]  itype;
    logic [5:0]  funct6;
    logic [7:0]  rs1_addr;
    logic [7:0]  rs2_addr;
    logic [7:0]  rd_addr;
    logic [11:0] imm_i;
    logic [11:0] imm_b;
    logic [3:0]  acc_code;

    assign itype    = instr[31:29];
    assign funct6   = instr[28:23];
    assign rs1_addr = {3'b000, instr[22:18]};
    assign rs2_addr = {3'b000, instr[17:13]};
    assign rd_addr  = {2'b00, instr[5:0]};
    assign imm_i    = instr[17:6];
    assign imm_b    = instr[11:0];
    assign acc_code = instr[9:6];

    always_comb begin
        dec = '0;
        unique case (itype)
            TYPE_ALU_I: begin
                dec.src1_addr = rs1_addr;
                dec.immediate = imm_i;
                dec.rd_addr   = rd_addr;
                dec.alu_funct = funct6[5:3];
                dec.src2_sel  = 1'b1;
                dec.wrd_en    = 1'b1;
            end
            TYPE_ALU_R: begin
                dec.src1_addr = rs1_addr;
                dec.src2_addr = rs2_addr;
                dec.rd_addr   = rd_addr;
                dec.alu_funct = funct6[5:3];
                dec.wrd_en    = 1'b1;
            end
            TYPE_LOAD: begin
                // Address is rs1 + imm, so the ALU is forced to ADD.
                dec.src1_addr = rs1_addr;
                dec.immediate = imm_i;
                dec.rd_addr   = rd_addr;
                dec.alu_funct = ALU_ADD;
                dec.src2_sel  = 1'b1;
                dec.wrd_sel   = 1'b1;
                dec.wrd_en    = 1'b1;
            end
            TYPE_BRANCH: begin
                dec.src1_addr = rs1_addr;
                dec.src2_addr = rs2_addr;
                dec.immediate = imm_b;
                dec.br_funct  = funct6[5:3];
                dec.pc_sel    = 1'b1;
            end
            TYPE_SYS: begin
                if (funct6 == FUNCT6_JUMP) begin
                    dec.immediate = imm_b;
                    dec.pc_sel    = 1'b1;
                    dec.jump_sel  = 1'b1;
                end else if (funct6 == FUNCT6_ACCEL) begin
                    // One-hot strobe; codes 10..15 are reserved and idle.
                    if (acc_code < 4'(ACC_NUM_CMDS)) begin
                        dec.accel = ACC_NUM_CMDS'(1) << acc_code;
                    end
                end
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Registered instruction decoder. Decode of instr sampled at a rising
// edge appears on the outputs after that edge (1-cycle latency).
// Ports:
//   clk, rst           - clock, synchronous active-high reset (clears all outputs)
//   instr              - 32-bit instruction word
//   src1/src2_addr     - register read addresses
//   immediate          - decoded 12-bit immediate
//   rd_addr            - writeback address
//   alu_funct/br_funct - ALU op and branch condition
//   pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en - control strobes
//   decode_layer .. send_optimal_move - one-hot accelerator commands
module instruction_decoder
    import instruction_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [7:0]  src1_addr,
    output logic [7:0]  src2_addr,
    output logic [11:0] immediate,
    output logic [7:0]  rd_addr,
    output logic [2:0]  alu_funct,
    output logic [2:0]  br_funct,
    output logic        pc_sel,
    output logic        jump_sel,
    output logic        src2_sel,
    output logic        wrd_sel,
    output logic        wrd_en,
    output logic        decode_layer,
    output logic        compute_grid,
    output logic        decode_layer_info,
    output logic        compute_ifmap,
    output logic        send_layer_info,
    output logic        load_weights,
    output logic        load_bias,
    output logic        send_systolic_data,
    output logic        set_ifmap_o,
    output logic        send_optimal_move
);

    decode_t dec_next;
    decode_t dec_q;

    instr_decode_comb u_decode (
        .instr (instr),
        .dec   (dec_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_next;
        end
    end

    assign src1_addr          = dec_q.src1_addr;
    assign src2_addr          = dec_q.src2_addr;
    assign immediate          = dec_q.immediate;
    assign rd_addr            = dec_q.rd_addr;
    assign alu_funct          = dec_q.alu_funct;
    assign br_funct           = dec_q.br_funct;
    assign pc_sel             = dec_q.pc_sel;
    assign jump_sel           = dec_q.jump_sel;
    assign src2_sel           = dec_q.src2_sel;
    assign wrd_sel            = dec_q.wrd_sel;
    assign wrd_en             = dec_q.wrd_en;
    assign decode_layer       = dec_q.accel[ACC_DECODE_LAYER];
    assign compute_grid       = dec_q.accel[ACC_COMPUTE_GRID];
    assign decode_layer_info  = dec_q.accel[ACC_DECODE_LAYER_INFO];
    assign compute_ifmap      = dec_q.accel[ACC_COMPUTE_IFMAP];
    assign send_layer_info    = dec_q.accel[ACC_SEND_LAYER_INFO];
    assign load_weights       = dec_q.accel[ACC_LOAD_WEIGHTS];
    assign load_bias          = dec_q.accel[ACC_LOAD_BIAS];
    assign send_systolic_data = dec_q.accel[ACC_SEND_SYSTOLIC_DATA];
    assign set_ifmap_o        = dec_q.accel[ACC_SET_IFMAP_O];
    assign send_optimal_move  = dec_q.accel[ACC_SEND_OPTIMAL_MOVE];

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed testbench for instruction_decoder. Each step drives one
// instruction (and rst), pushes the hand-computed expected output word
// onto exp_q, then samples 1 time unit after the next rising edge.
// Output word layout: {src1, src2, imm, rd, alu, br,
//   {pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en}, accel[9:0]}
// where accel bit i is accelerator command code i.
module tb_instruction_decoder;

    localparam int OW = 57;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [7:0]  src1_addr, src2_addr, rd_addr;
    logic [11:0] immediate;
    logic [2:0]  alu_funct, br_funct;
    logic        pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en;
    logic        decode_layer, compute_grid, decode_layer_info, compute_ifmap;
    logic        send_layer_info, load_weights, load_bias, send_systolic_data;
    logic        set_ifmap_o, send_optimal_move;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    instruction_decoder dut (
        .clk                (clk),
        .rst                (rst),
        .instr              (instr),
        .src1_addr          (src1_addr),
        .src2_addr          (src2_addr),
        .immediate          (immediate),
        .rd_addr            (rd_addr),
        .alu_funct          (alu_funct),
        .br_funct           (br_funct),
        .pc_sel             (pc_sel),
        .jump_sel           (jump_sel),
        .src2_sel           (src2_sel),
        .wrd_sel            (wrd_sel),
        .wrd_en             (wrd_en),
        .decode_layer       (decode_layer),
        .compute_grid       (compute_grid),
        .decode_layer_info  (decode_layer_info),
        .compute_ifmap      (compute_ifmap),
        .send_layer_info    (send_layer_info),
        .load_weights       (load_weights),
        .load_bias          (load_bias),
        .send_systolic_data (send_systolic_data),
        .set_ifmap_o        (set_ifmap_o),
        .send_optimal_move  (send_optimal_move)
    );

    assign obs = {src1_addr, src2_addr, immediate, rd_addr, alu_funct, br_funct,
                  pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en,
                  send_optimal_move, set_ifmap_o, send_systolic_data, load_bias,
                  load_weights, send_layer_info, compute_ifmap, decode_layer_info,
                  compute_grid, decode_layer};

    function automatic logic [OW-1:0] mk(input logic [7:0] s1, input logic [7:0] s2,
                                         input logic [11:0] imm, input logic [7:0] rd,
                                         input logic [2:0] alu, input logic [2:0] br,
                                         input logic [4:0] ctrl, input logic [9:0] acc);
        return {s1, s2, imm, rd, alu, br, ctrl, acc};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag);
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic r, input logic [31:0] i,
                        input logic [OW-1:0] e);
        rst   = r;
        instr = i;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // ctrl = {pc_sel, jump_sel, src2_sel, wrd_sel, wrd_en}
    initial begin
        rst   = 1'b1;
        instr = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;

        // Reset holds everything at zero even with a non-zero instr.
        step("reset", 1'b1, 32'hFFFF_FFFF, '0);

        // R-type ADD-code MUL: r0x0C * r0x0D -> r0x15
        step("r_type", 1'b0, {3'b001, 6'b000000, 5'h0C, 5'h0D, 7'b0, 6'h15},
             mk(8'h0C, 8'h0D, 12'h000, 8'h15, 3'b000, 3'b000, 5'b00001, 10'b0));

        // I-type ADD imm=1 -> r0x08
        step("i_add", 1'b0, {3'b000, 6'b100000, 5'h00, 12'h001, 6'h08},
             mk(8'h00, 8'h00, 12'h001, 8'h08, 3'b100, 3'b000, 5'b00101, 10'b0));

        // I-type OR imm=0x0AB -> r0x0B
        step("i_or", 1'b0, {3'b000, 6'b110000, 5'h00, 12'h0AB, 6'h0B},
             mk(8'h00, 8'h00, 12'h0AB, 8'h0B, 3'b110, 3'b000, 5'b00101, 10'b0));

        // I-type SRL with funct6 low bits set and rs1=0x1F, imm all ones
        step("i_srl", 1'b0, {3'b000, 6'b101011, 5'h1F, 12'hFFF, 6'h3F},
             mk(8'h1F, 8'h00, 12'hFFF, 8'h3F, 3'b101, 3'b000, 5'b00101, 10'b0));

        // R-type XOR with nonzero middle bits that must not leak to immediate
        step("r_xor", 1'b0, {3'b001, 6'b111000, 5'h11, 5'h02, 7'h7F, 6'h17},
             mk(8'h11, 8'h02, 12'h000, 8'h17, 3'b111, 3'b000, 5'b00001, 10'b0));

        // LOAD: funct6 ignored, ALU forced to ADD, writeback from memory
        step("load", 1'b0, {3'b010, 6'b011000, 5'h0C, 12'h123, 6'h17},
             mk(8'h0C, 8'h00, 12'h123, 8'h17, 3'b100, 3'b000, 5'b00111, 10'b0));

        // Branch BNE r0x08, r0x07, offset 11 (rd field bits are not an rd)
        step("branch", 1'b0, {3'b011, 6'b001000, 5'h08, 5'h07, 1'b0, 12'd11},
             mk(8'h08, 8'h07, 12'd11, 8'h00, 3'b000, 3'b001, 5'b10000, 10'b0));

        // Jump offset 201
        step("jump", 1'b0, {3'b111, 6'b000111, 11'b0, 12'd201},
             mk(8'h00, 8'h00, 12'd201, 8'h00, 3'b000, 3'b000, 5'b11000, 10'b0));

        // Accelerator commands
        step("acc6_load_bias", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd6, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b00_0100_0000));
        step("acc7_send_systolic", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd7, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b00_1000_0000));
        step("acc8_set_ifmap_o", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd8, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b01_0000_0000));
        step("acc2_decode_layer_info", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd2, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b00_0000_0100));
        step("acc9_send_optimal_move", 1'b0, {3'b111, 6'b111111, 13'h1FFF, 4'd9, 6'h3F},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b10_0000_0000));
        step("acc0_decode_layer", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd0, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b00_0000_0001));
        step("acc12_none", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd12, 6'b0}, '0);
        step("acc15_none", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd15, 6'b0}, '0);

        // NOPs: reserved types and unlisted TYPE_SYS function
        step("nop_type100", 1'b0, {3'b100, 29'h1FFF_FFFF}, '0);
        step("nop_type110", 1'b0, {3'b110, 6'b000111, 23'h12_3456}, '0);
        step("nop_sys_funct", 1'b0, {3'b111, 6'b000110, 11'h7FF, 12'hFFF}, '0);

        // All-zero word is ALU-I MUL of r0 into r0
        step("instr_zero", 1'b0, 32'h0000_0000,
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00101, 10'b0));

        // Mid-stream reset: load accepted, then reset drops the jump, then resume
        step("pre_reset_load", 1'b0, {3'b010, 6'b000000, 5'h03, 12'h055, 6'h04},
             mk(8'h03, 8'h00, 12'h055, 8'h04, 3'b100, 3'b000, 5'b00111, 10'b0));
        step("mid_reset", 1'b1, {3'b111, 6'b000111, 11'b0, 12'd77}, '0);
        step("resume_acc5", 1'b0, {3'b111, 6'b111111, 13'b0, 4'd5, 6'b0},
             mk(8'h00, 8'h00, 12'h000, 8'h00, 3'b000, 3'b000, 5'b00000, 10'b00_0010_0000));
        step("resume_branch", 1'b0, {3'b011, 6'b101000, 5'h15, 5'h17, 1'b1, 12'hABC},
             mk(8'h15, 8'h17, 12'hABC, 8'h00, 3'b000, 3'b101, 5'b10000, 10'b0));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
